// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Request sequencer that sits directly in front of data_memory. One
// LOAD/STORE/PUSH/POP request is accepted at a time; the unit computes the
// effective address, drives the memory bus, absorbs the memory's one-cycle
// registered read latency and keeps a hardware stack pointer.
//
// Handshake: in_req is sampled only while out_busy is low (IDLE). A request
// presented while busy is dropped, not queued; the requester re-issues after
// it has seen the one-cycle out_done pulse. out_err is only meaningful while
// out_done is high.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_req          request strobe
//   in_op           00 LOAD, 01 STORE, 10 PUSH, 11 POP
//   in_base         base address (LOAD/STORE)
//   in_offset       signed 8-bit offset (LOAD/STORE)
//   in_wdata        write data (STORE/PUSH)
//   out_busy        high in every state except IDLE
//   out_done        one-cycle completion pulse
//   out_err         stack overflow/underflow, valid with out_done
//   out_rdata       last read result, held until the next successful read
//   out_sp          stack pointer (next free slot)
//   mem_addr        memory address
//   mem_write_en    memory write enable
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid the cycle after the address
//   dbg_state       current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] SP_RESET = 10'h3FF,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 10'h300
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_req,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [7:0]        in_offset,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_err,
    output logic [DATA_W-1:0] out_rdata,
    output logic [ADDR_W-1:0] out_sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic              err_q;

    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] ls_addr;
    logic [ADDR_W-1:0] req_addr;
    logic              req_err;
    logic              req_write;
    logic              op_q_write;

    // Effective address for LOAD/STORE wraps modulo 2^ADDR_W by plain truncation.
    assign offset_ext = {{(ADDR_W-8){in_offset[7]}}, in_offset};
    assign ls_addr    = in_base + offset_ext;

    // STORE and PUSH are the writing ops: op[0] differs between them, so test explicitly.
    assign req_write  = (in_op == OP_STORE) || (in_op == OP_PUSH);
    assign op_q_write = (op_q == OP_STORE) || (op_q == OP_PUSH);

    always_comb begin
        req_addr = ls_addr;
        req_err  = 1'b0;
        case (in_op)
            OP_PUSH: begin
                req_addr = out_sp;
                req_err  = (out_sp < SP_LIMIT);
            end
            OP_POP: begin
                // out_sp points at the free slot, so the top item is one above it.
                req_addr = out_sp + ADDR_ONE;
                req_err  = (out_sp == SP_RESET);
            end
            default: begin
                req_addr = ls_addr;
                req_err  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= OP_LOAD;
            err_q        <= 1'b0;
            out_sp       <= SP_RESET;
            out_rdata    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_write_en <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_req) begin
                        op_q  <= in_op;
                        err_q <= req_err;
                        if (req_err) begin
                            // Rejected stack op: no bus activity, straight to DONE.
                            state <= S_DONE;
                        end else begin
                            state        <= S_ISSUE;
                            mem_addr     <= req_addr;
                            mem_write_en <= req_write;
                            // Reads leave the last write data on the bus.
                            if (req_write) begin
                                mem_wdata <= in_wdata;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    mem_write_en <= 1'b0;
                    if (op_q_write) begin
                        if (op_q == OP_PUSH) begin
                            out_sp <= out_sp - ADDR_ONE;
                        end
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    out_rdata <= mem_rdata;
                    if (op_q == OP_POP) begin
                        out_sp <= out_sp + ADDR_ONE;
                    end
                    state <= S_DONE;
                end
                default: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_busy  = (state != S_IDLE);
    assign out_done  = (state == S_DONE);
    assign out_err   = (state == S_DONE) && err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Bench for mem_access_unit with a behavioural 1 KiB data_memory attached.
// The stack limit is lowered to 10'h3FD so the fourth PUSH overflows.
// The request driver computes the expected result from its own memory and
// stack model and pushes it to queues; a monitor pops and compares on every
// out_done pulse.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] SP_RESET = 10'h3FF;
    localparam logic [ADDR_W-1:0] SP_LIMIT = 10'h3FD;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    logic              clk;
    logic              rst_n;
    logic              in_req;
    logic [1:0]        in_op;
    logic [ADDR_W-1:0] in_base;
    logic [7:0]        in_offset;
    logic [DATA_W-1:0] in_wdata;
    logic              out_busy;
    logic              out_done;
    logic              out_err;
    logic [DATA_W-1:0] out_rdata;
    logic [ADDR_W-1:0] out_sp;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected-result queues, one entry per request, popped at out_done.
    logic              exp_err_q[$];
    logic [DATA_W-1:0] exp_rdata_q[$];
    logic [ADDR_W-1:0] exp_sp_q[$];

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ref_sp;
    logic [DATA_W-1:0] ref_rdata;

    // Values the driver holds on the request lines while a request is in flight.
    logic [1:0]        hold_op;
    logic [ADDR_W-1:0] hold_base;
    logic [7:0]        hold_off;
    logic [DATA_W-1:0] hold_wdata;

    // Behavioural data_memory: registered read, synchronous write.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    mem_access_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SP_RESET(SP_RESET),
        .SP_LIMIT(SP_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_req      (in_req),
        .in_op       (in_op),
        .in_base     (in_base),
        .in_offset   (in_offset),
        .in_wdata    (in_wdata),
        .out_busy    (out_busy),
        .out_done    (out_done),
        .out_err     (out_err),
        .out_rdata   (out_rdata),
        .out_sp      (out_sp),
        .mem_addr    (mem_addr),
        .mem_write_en(mem_write_en),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dbg_state   (dbg_state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // ---------------------------------------------------------------- check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n && out_done) begin
            if (exp_err_q.size() == 0) begin
                check("unexpected_done", {31'd0, out_done}, 32'd0);
            end else begin
                check("done_err",   {31'd0, out_err},  {31'd0, exp_err_q.pop_front()});
                check("done_rdata", {24'd0, out_rdata}, {24'd0, exp_rdata_q.pop_front()});
                check("done_sp",    {22'd0, out_sp},    {22'd0, exp_sp_q.pop_front()});
            end
        end
    end

    // ---------------------------------------------------------------- driver
    // Issues one request at the next negedge. With hold set, in_req stays high
    // after acceptance carrying the hold_* request, which must be ignored until
    // the unit is back in IDLE.
    task automatic do_req(input logic [1:0] op, input logic [ADDR_W-1:0] base,
                          input logic [7:0] off, input logic [DATA_W-1:0] wd,
                          input bit hold);
        logic              e_err;
        logic [ADDR_W-1:0] e_addr;
        logic [ADDR_W-1:0] prev_addr;
        bit                is_wr;
        int                lat;
        int                done_cyc;
        int                wcount;

        @(negedge clk);
        in_req    = 1'b1;
        in_op     = op;
        in_base   = base;
        in_offset = off;
        in_wdata  = wd;
        prev_addr = mem_addr;

        // Model
        is_wr = (op == OP_STORE) || (op == OP_PUSH);
        case (op)
            OP_PUSH: begin e_addr = ref_sp;      e_err = (ref_sp < SP_LIMIT);  end
            OP_POP:  begin e_addr = ref_sp + 1;  e_err = (ref_sp == SP_RESET); end
            default: begin e_addr = base + {{2{off[7]}}, off}; e_err = 1'b0;   end
        endcase
        if (!e_err) begin
            if (is_wr) ref_mem[e_addr] = wd;
            else       ref_rdata = ref_mem[e_addr];
            if (op == OP_PUSH) ref_sp = ref_sp - 1;
            if (op == OP_POP)  ref_sp = ref_sp + 1;
        end
        exp_err_q.push_back(e_err);
        exp_rdata_q.push_back(ref_rdata);
        exp_sp_q.push_back(ref_sp);
        lat = e_err ? 1 : (is_wr ? 2 : 3);

        @(posedge clk);   // acceptance edge E0
        done_cyc = 0;
        wcount   = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) begin
                    in_op     = hold_op;
                    in_base   = hold_base;
                    in_offset = hold_off;
                    in_wdata  = hold_wdata;
                end else begin
                    in_req = 1'b0;
                end
                check("busy_after_accept", {31'd0, out_busy}, 32'd1);
                check("issue_addr", {22'd0, mem_addr}, {22'd0, e_err ? prev_addr : e_addr});
            end
            if (mem_write_en) begin
                wcount++;
                check("write_data", {24'd0, mem_wdata}, {24'd0, wd});
            end
            if (out_done) begin
                done_cyc = c;
                break;
            end
        end
        check("done_latency", done_cyc, lat);
        check("write_pulses", wcount, (is_wr && !e_err) ? 1 : 0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_n     = 1'b0;
        in_req    = 1'b0;
        in_op     = OP_LOAD;
        in_base   = '0;
        in_offset = '0;
        in_wdata  = '0;
        ref_sp    = SP_RESET;
        ref_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, out_busy},     32'd0);
        check("rst_done",  {31'd0, out_done},     32'd0);
        check("rst_err",   {31'd0, out_err},      32'd0);
        check("rst_we",    {31'd0, mem_write_en}, 32'd0);
        check("rst_sp",    {22'd0, out_sp},       {22'd0, SP_RESET});
        check("rst_rdata", {24'd0, out_rdata},    32'd0);
        check("rst_addr",  {22'd0, mem_addr},     32'd0);
        check("rst_wdata", {24'd0, mem_wdata},    32'd0);
        check("rst_state", {30'd0, dbg_state},    32'd0);
        rst_n = 1'b1;

        // Underflow at reset
        do_req(OP_POP, '0, 8'h00, 8'h00, 1'b0);

        // Reset during ISSUE of a STORE, after a PUSH moved the stack pointer
        do_req(OP_PUSH, '0, 8'h00, 8'h02, 1'b0);
        @(negedge clk);
        in_req = 1'b1; in_op = OP_STORE; in_base = 10'h020; in_offset = 8'h00; in_wdata = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        in_req = 1'b0;
        check("mid_store_we", {31'd0, mem_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_we",    {31'd0, mem_write_en}, 32'd0);
        check("arst_sp",    {22'd0, out_sp},       {22'd0, SP_RESET});
        check("arst_state", {30'd0, dbg_state},    32'd0);
        check("arst_busy",  {31'd0, out_busy},     32'd0);
        ref_sp    = SP_RESET;
        ref_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Store/load round trip with negative offset, then wrapping load
        do_req(OP_STORE, 10'h010, 8'hFE, 8'h55, 1'b0);
        do_req(OP_LOAD,  10'h010, 8'hFE, 8'h00, 1'b0);
        do_req(OP_LOAD,  10'h3FF, 8'h02, 8'h00, 1'b0);

        // Stack order, overflow, pops, underflow
        do_req(OP_PUSH, '0, 8'h00, 8'h02, 1'b0);
        do_req(OP_PUSH, '0, 8'h00, 8'h04, 1'b0);
        do_req(OP_PUSH, '0, 8'h00, 8'h08, 1'b0);
        do_req(OP_PUSH, '0, 8'h00, 8'h10, 1'b0);
        do_req(OP_POP,  '0, 8'h00, 8'h00, 1'b0);
        do_req(OP_POP,  '0, 8'h00, 8'h00, 1'b0);
        do_req(OP_POP,  '0, 8'h00, 8'h00, 1'b0);
        do_req(OP_POP,  '0, 8'h00, 8'h00, 1'b0);

        // Request held high during a LOAD: the STORE runs only after DONE -> IDLE
        hold_op = OP_STORE; hold_base = 10'h030; hold_off = 8'h05; hold_wdata = 8'h77;
        do_req(OP_LOAD,  10'h010, 8'hFE, 8'h00, 1'b1);
        do_req(OP_STORE, 10'h030, 8'h05, 8'h77, 1'b0);
        do_req(OP_LOAD,  10'h035, 8'h00, 8'h00, 1'b0);

        // Random mix over a small window so loads hit earlier stores
        for (int i = 0; i < 40; i++) begin
            do_req(2'($urandom_range(0, 3)), 10'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request sequencer directly upstream of `data_memory`. It accepts one load/store/push/pop request at a time from the core, computes the effective address, and drives the memory's address, write-enable and write-data ports. It absorbs the memory's one-cycle registered read latency and maintains a hardware stack pointer over a fixed region of the 1 KiB data memory.

## Interface
Parameters:
- `ADDR_W`, 10: memory address width.
- `DATA_W`, 8: data width.
- `SP_RESET`, 10'h3FF: stack pointer reset value; this is the top of the stack and the empty position.
- `SP_LIMIT`, 10'h300: lowest address the stack may occupy.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_req`  in  1  request strobe; sampled only in IDLE.
- `in_op`  in  2  operation: 00 LOAD, 01 STORE, 10 PUSH, 11 POP.
- `in_base`  in  ADDR_W  base address (LOAD/STORE).
- `in_offset`  in  8  signed two's-complement offset (LOAD/STORE).
- `in_wdata`  in  DATA_W  write data (STORE/PUSH).
- `out_busy`  out  1  high in every state except IDLE.
- `out_done`  out  1  one-cycle completion pulse.
- `out_err`  out  1  valid with `out_done`; stack overflow or underflow.
- `out_rdata`  out  DATA_W  read result; held until the next successful read.
- `out_sp`  out  ADDR_W  current stack pointer, which is the next free slot.
- `mem_addr`  out  ADDR_W  to `data_memory.in_addr`.
- `mem_write_en`  out  1  to `data_memory.in_write_en`.
- `mem_wdata`  out  DATA_W  to `data_memory.in_data`.
- `mem_rdata`  in  DATA_W  from `data_memory.out_data`; valid the cycle after the address is presented.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** when `in_req` is 1, latch `in_op` and `in_wdata`, then compute the address:
  - LOAD/STORE: `in_base + sign_extend(in_offset)`, modulo 2^ADDR_W (wraps, no error).
  - PUSH: address = `out_sp`.
  - POP: address = `out_sp + 1`.
- **Error checks in IDLE:**
  - PUSH when `out_sp < SP_LIMIT` is full. POP when `out_sp == SP_RESET` is empty.
  - On error: go directly to DONE with `out_err`=1. No memory access; `out_sp` and `out_rdata` unchanged.
- **ISSUE (1 cycle):**
  - Drive `mem_addr`.
  - For STORE/PUSH: drive `mem_wdata` and set `mem_write_en`=1, then go to DONE.
  - For LOAD/POP: `mem_write_en`=0, then go to WAIT.
  - PUSH decrements `out_sp` at the end of ISSUE.
- **WAIT (1 cycle):** capture `mem_rdata` into `out_rdata` at the end of the cycle. POP increments `out_sp` at the same edge.
- **DONE (1 cycle):** `out_done`=1, `out_err` per the check, then return to IDLE.
- **Bus behaviour:**
  - `mem_write_en` is 1 only in ISSUE of STORE/PUSH and 0 everywhere else.
  - `mem_addr` and `mem_wdata` hold their last values outside ISSUE and WAIT.
- **Busy handling:** `in_req` while busy is ignored and not queued. The requester re-issues after `out_done`.
- **Reset values:**
  - `out_sp` = SP_RESET.
  - `out_busy`, `out_done`, `out_err`, `mem_write_en` = 0.
  - `out_rdata`, `mem_addr`, `mem_wdata` = 0.
- **Reset mid-operation:** asynchronous return to IDLE; `mem_write_en` drops immediately. Any partial stack update is discarded and SP is reset.

## Timing
- Define edge E0 as the edge that samples `in_req` in IDLE.
- STORE/PUSH:
  - ISSUE occupies the cycle after E0; the memory write happens at E1.
  - `out_done` is high in the cycle after E1.
  - Next request is accepted at E3 at the earliest.
- LOAD/POP:
  - ISSUE follows E0; `mem_rdata` is valid after E1.
  - `out_rdata` updates at E2; `out_done` is high after E2.
  - Next request is accepted at E4 at the earliest.
- Errors: `out_done` and `out_err` are high in the cycle after E0.
- `out_busy` rises after E0 and falls when DONE exits.
- `out_sp` changes exactly once per successful PUSH/POP, at the edges given above.

## Test plan
- **Reset:** hold `rst_n`=0 mid-STORE (during ISSUE) → `mem_write_en` drops to 0 asynchronously, `out_sp`=10'h3FF, state is IDLE.
- **STORE/LOAD round trip:**
  - STORE base=10'h010, offset=8'hFE, data=8'h55 → `mem_addr`=10'h00E, `mem_write_en` high for exactly 1 cycle.
  - Then LOAD with the same base and offset → `out_rdata`=8'h55, `out_done` 3 cycles after the accept edge.
- **Address wrap:** LOAD base=10'h3FF, offset=8'h02 → `mem_addr`=10'h001, `out_err`=0.
- **Stack order:**
  - PUSH 8'h02, 8'h04, 8'h08 → `out_sp` steps 3FF→3FE→3FD→3FC.
  - Three POPs → returns 8'h08, 8'h04, 8'h02; `out_sp` ends at 3FF.
- **Underflow/overflow:**
  - POP at reset → `out_err`=1 the cycle after accept; no memory access; SP unchanged.
  - With SP_LIMIT=10'h3FD, the 4th PUSH → `out_err`=1; `out_sp` stays 3FC.
- **Busy ignore:** hold `in_req`=1 with a different op during a LOAD → only the first op executes. The second is accepted only after DONE → IDLE.
